wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges pipeline WB writes with a 2-entry
// queue of long-latency results onto the single register-file write port.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pipe_reg/wd/wdata     pipeline WB-stage write request
//   flush_i               cancels the pipeline write of this cycle
//   lu_valid/wd/wdata     long-latency result offer
//   lu_ready              result queue has a free slot
//   rf_we/waddr/wdata     registered register-file write port
//   stall_req             registered pipeline freeze (starved queue head)
//   pending_mask          one bit per register targeted by a queued result

module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_reg,
    input  logic [4:0]  pipe_wd,
    input  logic [31:0] pipe_wdata,
    input  logic        flush_i,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wd,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic [31:0] pending_mask
);

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    // Slot 0 is always the head; slot 1 is the younger entry.
    logic [1:0]  cnt;
    logic [4:0]  q_wd   [2];
    logic [31:0] q_data [2];
    logic [2:0]  starve_cnt;

    logic        fifo_empty;
    logic        enq;
    logic        pipe_act;
    logic        grant_fifo;
    logic [2:0]  starve_nxt;
    logic        wr_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign fifo_empty = (cnt == 2'd0);
    assign lu_ready   = (cnt != 2'd2);
    assign enq        = lu_valid && lu_ready && (lu_wd != 5'd0);
    assign pipe_act   = pipe_reg && (pipe_wd != 5'd0)
                      && !flush_i && !stall_req;
    // stall_req guarantees a bubble, so the head wins unconditionally.
    assign grant_fifo = !fifo_empty && (stall_req || !pipe_act);

    always_comb begin
        wr_we   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        unique case (1'b1)
            grant_fifo: begin
                wr_we   = 1'b1;
                wr_addr = q_wd[0];
                wr_data = q_data[0];
            end
            pipe_act: begin
                wr_we   = 1'b1;
                wr_addr = pipe_wd;
                wr_data = pipe_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (fifo_empty || grant_fifo)
            starve_nxt = 3'd0;
        else if (starve_cnt >= SMAX)
            starve_nxt = SMAX;
        else
            starve_nxt = starve_cnt + 3'd1;
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (i < int'(cnt))
                pending_mask[q_wd[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 2'd0;
            q_wd[0]    <= 5'd0;
            q_wd[1]    <= 5'd0;
            q_data[0]  <= 32'd0;
            q_data[1]  <= 32'd0;
            starve_cnt <= 3'd0;
            stall_req  <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
        end else begin
            rf_we      <= wr_we;
            rf_waddr   <= wr_addr;
            rf_wdata   <= wr_data;
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SMAX);
            case ({enq, grant_fifo})
                2'b10: begin
                    q_wd[cnt[0]]   <= lu_wd;
                    q_data[cnt[0]] <= lu_wdata;
                    cnt            <= cnt + 2'd1;
                end
                2'b01: begin
                    q_wd[0]   <= q_wd[1];
                    q_data[0] <= q_data[1];
                    cnt       <= cnt - 2'd1;
                end
                // Only reachable with one entry: new result becomes head.
                2'b11: begin
                    q_wd[0]   <= lu_wd;
                    q_data[0] <= lu_wdata;
                end
                default: ;
            endcase
        end
    end

    pipe_reg_in_stall: assert property (
        @(posedge clk) disable iff (rst) stall_req |-> !pipe_reg
    );

endmodule
